// File: rtl/cpu_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : cpu_controller_if
// Purpose  : Instruction-side and datapath-control signals of cpu_controller.
// Revision : 1.0 - initial release
// ============================================================================
interface cpu_controller_if #(
   parameter int DATA_W = 16
);
   logic [DATA_W-1:0] in_i;
   logic              load_i;
   logic              s_i;
   logic              w_o;
   logic [2:0]        readnum_o;
   logic [2:0]        writenum_o;
   logic              write_o;
   logic [1:0]        vsel_o;
   logic              loada_o;
   logic              loadb_o;
   logic              asel_o;
   logic              bsel_o;
   logic [1:0]        shift_o;
   logic [1:0]        ALUop_o;
   logic              loadc_o;
   logic              loads_o;
   logic [DATA_W-1:0] sximm8_o;
   logic [DATA_W-1:0] sximm5_o;

   modport master (
      output in_i, load_i, s_i,
      input  w_o, readnum_o, writenum_o, write_o, vsel_o, loada_o, loadb_o,
             asel_o, bsel_o, shift_o, ALUop_o, loadc_o, loads_o, sximm8_o, sximm5_o
   );

   modport slave (
      input  in_i, load_i, s_i,
      output w_o, readnum_o, writenum_o, write_o, vsel_o, loada_o, loadb_o,
             asel_o, bsel_o, shift_o, ALUop_o, loadc_o, loads_o, sximm8_o, sximm5_o
   );
endinterface
`default_nettype wire

// File: rtl/cpu_controller.sv
`default_nettype none
// ============================================================================
// Module   : cpu_controller
// Purpose  : Instruction register, decoder and Moore control FSM for the datapath.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_controller #(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   cpu_controller_if.slave   bus
);
   typedef enum logic [2:0] {
      S_WAIT   = 3'd0,
      S_DECODE = 3'd1,
      S_GETA   = 3'd2,
      S_GETB   = 3'd3,
      S_OPER   = 3'd4,
      S_WREG   = 3'd5,
      S_WIMM   = 3'd6
   } state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] ir_q, ir_d;

   logic [2:0] op, rn, rd, rm;
   logic [1:0] sub, sh;
   logic       is_alu, is_movr, is_movi, is_cmp;

   assign op  = ir_q[15:13];
   assign sub = ir_q[12:11];
   assign rn  = ir_q[10:8];
   assign rd  = ir_q[7:5];
   assign sh  = ir_q[4:3];
   assign rm  = ir_q[2:0];

   assign is_alu  = (op == 3'b101);
   assign is_movr = (op == 3'b110) && (sub == 2'b00);
   assign is_movi = (op == 3'b110) && (sub == 2'b10);
   assign is_cmp  = is_alu && (sub == 2'b01);

   assign bus.sximm8_o = {{(DATA_W-8){ir_q[7]}}, ir_q[7:0]};
   assign bus.sximm5_o = {{(DATA_W-5){ir_q[4]}}, ir_q[4:0]};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_WAIT;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
      end
   end

   // IR capture is combinational here so a load+s edge executes the new word.
   always_comb begin
      ir_d           = ir_q;
      state_d        = state_q;
      bus.w_o        = 1'b0;
      bus.readnum_o  = 3'd0;
      bus.writenum_o = 3'd0;
      bus.write_o    = 1'b0;
      bus.vsel_o     = 2'b00;
      bus.loada_o    = 1'b0;
      bus.loadb_o    = 1'b0;
      bus.asel_o     = 1'b0;
      bus.bsel_o     = 1'b0;
      bus.shift_o    = 2'b00;
      bus.ALUop_o    = 2'b00;
      bus.loadc_o    = 1'b0;
      bus.loads_o    = 1'b0;
      unique case (state_q)
         S_WAIT: begin
            bus.w_o = 1'b1;
            if (bus.load_i) ir_d = bus.in_i;
            if (bus.s_i)    state_d = S_DECODE;
         end
         S_DECODE: begin
            if (is_movi)      state_d = S_WIMM;
            else if (is_movr) state_d = S_GETB;
            else if (is_alu)  state_d = S_GETA;
            else              state_d = S_WAIT;
         end
         S_GETA: begin
            bus.readnum_o = rn;
            bus.loada_o   = 1'b1;
            state_d       = S_GETB;
         end
         S_GETB: begin
            bus.readnum_o = rm;
            bus.loadb_o   = 1'b1;
            state_d       = S_OPER;
         end
         S_OPER: begin
            bus.shift_o = sh;
            bus.asel_o  = is_movr;
            bus.ALUop_o = is_movr ? 2'b00 : sub;
            if (is_cmp) begin
               bus.loads_o = 1'b1;
               state_d     = S_WAIT;
            end else begin
               bus.loadc_o = 1'b1;
               state_d     = S_WREG;
            end
         end
         S_WREG: begin
            bus.writenum_o = rd;
            bus.vsel_o     = 2'b00;
            bus.write_o    = 1'b1;
            state_d        = S_WAIT;
         end
         S_WIMM: begin
            bus.writenum_o = rn;
            bus.vsel_o     = 2'b10;
            bus.write_o    = 1'b1;
            state_d        = S_WAIT;
         end
         default: state_d = S_WAIT;
      endcase
   end
endmodule
`default_nettype wire

// File: tb/tb_cpu_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_controller
// Purpose  : Directed table-driven bench for cpu_controller with reset corner cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_controller;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   n_assert = 0;
   int   n_fail = 0;

   cpu_controller_if #(.DATA_W(16)) bus ();

   cpu_controller #(.DATA_W(16)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   always #5 clk = ~clk;

   // {w, readnum, writenum, write, vsel, loada, loadb, asel, bsel, shift, ALUop, loadc, loads}
   logic [19:0] ctl_act;
   assign ctl_act = {bus.w_o, bus.readnum_o, bus.writenum_o, bus.write_o, bus.vsel_o,
                     bus.loada_o, bus.loadb_o, bus.asel_o, bus.bsel_o, bus.shift_o,
                     bus.ALUop_o, bus.loadc_o, bus.loads_o};

   typedef struct {
      string       name;
      logic [15:0] in;
      logic        load;
      logic        s;
      logic [19:0] ctl;
      logic [15:0] sx8;
      logic [15:0] sx5;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [19:0] mk(input logic w, input logic [2:0] rn, input logic [2:0] wn,
                                      input logic wr, input logic [1:0] vs, input logic la,
                                      input logic lb, input logic as, input logic bs,
                                      input logic [1:0] sh, input logic [1:0] alu,
                                      input logic lc, input logic ls);
      return {w, rn, wn, wr, vs, la, lb, as, bs, sh, alu, lc, ls};
   endfunction

   function automatic void add(input string name, input logic [15:0] in, input logic ld,
                               input logic s, input logic [19:0] ctl,
                               input logic [15:0] sx8, input logic [15:0] sx5);
      vec_t v;
      v.name = name; v.in = in; v.load = ld; v.s = s;
      v.ctl = ctl; v.sx8 = sx8; v.sx5 = sx5;
      vecs.push_back(v);
   endfunction

   task automatic check(input string name, input logic [51:0] act, input logic [51:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual ctl=%h sx8=%h sx5=%h, required ctl=%h sx8=%h sx5=%h",
                  name, act[51:32], act[31:16], act[15:0], exp[51:32], exp[31:16], exp[15:0]);
      end
   endtask

   task automatic step(input logic [15:0] in, input logic ld, input logic s);
      @(negedge clk);
      bus.in_i = in; bus.load_i = ld; bus.s_i = s;
      @(posedge clk);
      #1;
   endtask

   logic [19:0] IDLE, DEC;

   initial begin
      IDLE = mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
      DEC  = 20'h0;

      // MOV R3,#42
      add("movi42_dec",  16'hD32A, 1, 1, DEC, 16'h002A, 16'h000A);
      add("movi42_wimm", 16'h0000, 0, 0, mk(0,0,3,1,2'b10,0,0,0,0,2'b00,2'b00,0,0), 16'h002A, 16'h000A);
      add("movi42_wait", 16'h0000, 0, 0, IDLE, 16'h002A, 16'h000A);
      // MOV R1,#-1
      add("movim1_dec",  16'hD1FF, 1, 1, DEC, 16'hFFFF, 16'hFFFF);
      add("movim1_wimm", 16'h0000, 0, 0, mk(0,0,1,1,2'b10,0,0,0,0,2'b00,2'b00,0,0), 16'hFFFF, 16'hFFFF);
      add("movim1_wait", 16'h0000, 0, 0, IDLE, 16'hFFFF, 16'hFFFF);
      // ADD R2,R5,R3 with a stray load pulse mid-instruction
      add("add_dec",  16'hA543, 1, 1, DEC, 16'h0043, 16'h0003);
      add("add_geta", 16'hFFFF, 1, 0, mk(0,5,0,0,2'b00,1,0,0,0,2'b00,2'b00,0,0), 16'h0043, 16'h0003);
      add("add_getb", 16'hFFFF, 1, 0, mk(0,3,0,0,2'b00,0,1,0,0,2'b00,2'b00,0,0), 16'h0043, 16'h0003);
      add("add_oper", 16'h0000, 0, 0, mk(0,0,0,0,2'b00,0,0,0,0,2'b00,2'b00,1,0), 16'h0043, 16'h0003);
      add("add_wreg", 16'h0000, 0, 0, mk(0,0,2,1,2'b00,0,0,0,0,2'b00,2'b00,0,0), 16'h0043, 16'h0003);
      add("add_wait", 16'h0000, 0, 0, IDLE, 16'h0043, 16'h0003);
      // MOV R4,R3,sh=10
      add("movr_dec",  16'hC093, 1, 1, DEC, 16'hFF93, 16'hFFF3);
      add("movr_getb", 16'h0000, 0, 0, mk(0,3,0,0,2'b00,0,1,0,0,2'b00,2'b00,0,0), 16'hFF93, 16'hFFF3);
      add("movr_oper", 16'h0000, 0, 0, mk(0,0,0,0,2'b00,0,0,1,0,2'b10,2'b00,1,0), 16'hFF93, 16'hFFF3);
      add("movr_wreg", 16'h0000, 0, 0, mk(0,0,4,1,2'b00,0,0,0,0,2'b00,2'b00,0,0), 16'hFF93, 16'hFFF3);
      add("movr_wait", 16'h0000, 0, 0, IDLE, 16'hFF93, 16'hFFF3);
      // CMP R5,R3
      add("cmp_dec",  16'hAD03, 1, 1, DEC, 16'h0003, 16'h0003);
      add("cmp_geta", 16'h0000, 0, 0, mk(0,5,0,0,2'b00,1,0,0,0,2'b00,2'b00,0,0), 16'h0003, 16'h0003);
      add("cmp_getb", 16'h0000, 0, 0, mk(0,3,0,0,2'b00,0,1,0,0,2'b00,2'b00,0,0), 16'h0003, 16'h0003);
      add("cmp_oper", 16'h0000, 0, 0, mk(0,0,0,0,2'b00,0,0,0,0,2'b00,2'b01,0,1), 16'h0003, 16'h0003);
      add("cmp_wait", 16'h0000, 0, 0, IDLE, 16'h0003, 16'h0003);
      // AND R2,R5,R3 (sh=00): ALUop follows sub
      add("and_dec",  16'hB543, 1, 1, DEC, 16'h0043, 16'h0003);
      add("and_geta", 16'h0000, 0, 0, mk(0,5,0,0,2'b00,1,0,0,0,2'b00,2'b00,0,0), 16'h0043, 16'h0003);
      add("and_getb", 16'h0000, 0, 0, mk(0,3,0,0,2'b00,0,1,0,0,2'b00,2'b00,0,0), 16'h0043, 16'h0003);
      add("and_oper", 16'h0000, 0, 0, mk(0,0,0,0,2'b00,0,0,0,0,2'b00,2'b10,1,0), 16'h0043, 16'h0003);
      add("and_wreg", 16'h0000, 0, 0, mk(0,0,2,1,2'b00,0,0,0,0,2'b00,2'b00,0,0), 16'h0043, 16'h0003);
      add("and_wait", 16'h0000, 0, 0, IDLE, 16'h0043, 16'h0003);
      // Unsupported opcode
      add("nop_dec",  16'h0000, 1, 1, DEC, 16'h0000, 16'h0000);
      add("nop_wait", 16'h0000, 0, 0, IDLE, 16'h0000, 16'h0000);
      // s held high re-executes MOV R3,#42
      add("rep_dec1",  16'hD32A, 1, 1, DEC, 16'h002A, 16'h000A);
      add("rep_wimm1", 16'h0000, 0, 1, mk(0,0,3,1,2'b10,0,0,0,0,2'b00,2'b00,0,0), 16'h002A, 16'h000A);
      add("rep_wait1", 16'h0000, 0, 1, IDLE, 16'h002A, 16'h000A);
      add("rep_dec2",  16'h0000, 0, 1, DEC, 16'h002A, 16'h000A);
      add("rep_wimm2", 16'h0000, 0, 0, mk(0,0,3,1,2'b10,0,0,0,0,2'b00,2'b00,0,0), 16'h002A, 16'h000A);
      add("rep_wait2", 16'h0000, 0, 0, IDLE, 16'h002A, 16'h000A);
      // load without s stays in WAIT but updates IR
      add("load_only", 16'hD1FF, 1, 0, IDLE, 16'hFFFF, 16'hFFFF);

      bus.in_i = '0; bus.load_i = 1'b0; bus.s_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_state", {ctl_act, bus.sximm8_o, bus.sximm5_o}, {IDLE, 16'h0, 16'h0});
      @(negedge clk);
      reset_n = 1'b1;

      foreach (vecs[i]) begin
         step(vecs[i].in, vecs[i].load, vecs[i].s);
         check(vecs[i].name, {ctl_act, bus.sximm8_o, bus.sximm5_o},
               {vecs[i].ctl, vecs[i].sx8, vecs[i].sx5});
      end

      // Asynchronous reset while ADD sits in GETB
      step(16'hA543, 1, 1);
      step(16'h0000, 0, 0);
      step(16'h0000, 0, 0);
      check("midadd_getb", {ctl_act, bus.sximm8_o, bus.sximm5_o},
            {mk(0,3,0,0,2'b00,0,1,0,0,2'b00,2'b00,0,0), 16'h0043, 16'h0003});
      #2;
      reset_n = 1'b0;
      #1;
      check("midadd_reset", {ctl_act, bus.sximm8_o, bus.sximm5_o}, {IDLE, 16'h0, 16'h0});
      @(negedge clk);
      reset_n = 1'b1;
      step(16'h0000, 0, 0);
      check("post_reset_idle", {ctl_act, bus.sximm8_o, bus.sximm5_o}, {IDLE, 16'h0, 16'h0});
      step(16'hD32A, 1, 1);
      check("post_reset_dec", {ctl_act, bus.sximm8_o, bus.sximm5_o}, {DEC, 16'h002A, 16'h000A});
      step(16'h0000, 0, 0);
      check("post_reset_wimm", {ctl_act, bus.sximm8_o, bus.sximm5_o},
            {mk(0,0,3,1,2'b10,0,0,0,0,2'b00,2'b00,0,0), 16'h002A, 16'h000A});

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
